i2s_sample_player: RTL and testbench
====================================

# i2s_sample_player

Parametrised sample-playback engine that streams PCM samples from a synchronous block ROM into the I2S controller's ready/valid input. It supports mono or interleaved-stereo sample memories, one-shot or looping playback, start/stop control and a per-sample attenuation shift. It sits between `block_rom` and `i2s_controller` in the top level and replaces the hard-wired playback FSM there.

## Interface
- `W`, 16: sample width in bits, matching the I2S controller's `BITS`.
- `L`, 50000: ROM depth in words; `ADDR_W = $clog2(L)`.
- `CHANNELS`, 1: 1 = mono ROM, with each word sent to both L and R; 2 = stereo ROM, interleaved L,R,L,R starting at address 0. `L` must be even.
- `ROM_LAT`, 1: ROM read latency in cycles, from address to `rom_data` valid. Legal values are 1–2.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `play` in 1: single-cycle start request. Ignored while `busy`.
- `stop` in 1: single-cycle stop request.
- `loop_en` in 1: sampled at each end-of-memory. 1 = wrap to address 0.
- `vol_shift` in 3: attenuation, applied as an arithmetic right shift of 0–7. Sampled per fetched word.
- `rom_addr` out ADDR_W: ROM address, registered.
- `rom_data` in W: ROM read data.
- `o_data` out W: sample to the I2S controller.
- `o_ws` out 1: channel tag, 1 = left and 0 = right.
- `o_valid` out 1: sample valid.
- `o_ready` in 1: I2S controller ready.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse when playback ends.
- `amp_en` out 1: amplifier enable, high while `busy`.

## Operation
- **States:** IDLE, FETCH, WAIT_ROM, SEND_L, SEND_R, DONE.
- **IDLE:**
  - On `play`, set `rom_addr` to 0, clear the pending-stop flag and go to FETCH.
- **FETCH:**
  - `rom_addr` is stable.
  - Go to WAIT_ROM and count `ROM_LAT` cycles.
- **WAIT_ROM:**
  - After `ROM_LAT` cycles, register `rom_data >>> vol_shift` (signed) into the sample register.
  - Stereo, even address: go to SEND_L. Stereo, odd address: go to SEND_R.
  - Mono: go to SEND_L.
- **SEND_L:**
  - `o_valid`=1, `o_ws`=1.
  - On the handshake: in mono, stay on the same sample and go to SEND_R; in stereo, advance the address and go to FETCH.
- **SEND_R:**
  - `o_valid`=1, `o_ws`=0.
  - On the handshake, end the frame (see below).
- **End of frame** (after the handshake in SEND_R):
  - If the stop flag is set, go to DONE.
  - Else if `rom_addr == L-1`: with `loop_en` high, set `rom_addr` to 0 and go to FETCH; with `loop_en` low, go to DONE.
  - Else increment `rom_addr` and go to FETCH.
- **DONE:**
  - Pulse `done` for one cycle and go to IDLE.
- **stop:**
  - When asserted in any busy state, set a sticky flag.
  - Playback always finishes the current L/R frame, so the I2S controller never sees a lone left sample.
  - `stop` in IDLE has no effect.
- **play and stop in the same cycle in IDLE:** playback starts with the flag already set. Exactly one frame plays, then `done`.
- **Address arithmetic:** `rom_addr` never exceeds L-1. The comparison is made before the increment, so there is no out-of-range read.
- **Attenuation:** `vol_shift` is applied sign-preserving. Shift 0 passes the word unchanged. Shift 7 on 16'h8000 gives 16'hFF00.

## Timing
- **Reset values:** state IDLE, `rom_addr` 0, `o_valid` 0, `o_ws` 1, `o_data` 0, `busy` 0, `done` 0, `amp_en` 0, stop flag 0.
- **Reset mid-operation:** aborts immediately to IDLE, with no `done` pulse.
- **Output registers:** `o_data` and `o_ws` are registered and held stable while `o_valid`=1 and `o_ready`=0. `o_valid` does not drop without a handshake, except on reset.
- **Start latency:** `play` at cycle 0 gives FETCH at cycle 1 and first `o_valid` at cycle 2+`ROM_LAT`.
- **Mono frame:** takes 2+`ROM_LAT` cycles plus two handshakes.
- **Stereo frame:** takes 2×(2+`ROM_LAT`) cycles plus two handshakes.
- **`done` timing:** asserted the cycle after the final R handshake. `busy` falls the following cycle.
- **`amp_en`:** equals `busy`, registered.

## Structure
- **Package `i2s_pkg`:**
  - State enum `player_state_t`.
  - `WS_LEFT`=1 and `WS_RIGHT`=0.
  - Shared `BITS` default of 16, reused by `i2s_controller`.
- **Sub-module `sample_scaler`:** registered arithmetic shifter taking W-bit data and a 3-bit shift.
- **FSM, address counter, latency counter and stop flag:** in the top module.

## Test plan
- **Mono, L=4, ROM {1,2,3,4}, `o_ready` tied 1:** `play` produces the sequence (1,L)(1,R)(2,L)(2,R)…(4,R), then `done` one cycle after, then `busy`=0.
- **Stereo, L=4, ROM {A,B,C,D}:** output is (A,L)(B,R)(C,L)(D,R). No address above 3 is presented.
- **Backpressure:** hold `o_ready` low for 5 cycles during SEND_L. `o_data` and `o_ws` stay constant, `o_valid` stays 1, and no sample is skipped or duplicated.
- **Looping:** `loop_en`=1, mono L=2, 3 frames run, then `stop` during SEND_L. The sequence is 1,1,2,2,1,1 and ends after the R of that frame with a `done` pulse.
- **`vol_shift`:** `vol_shift`=3 on ROM word 16'h8000 gives 16'hF000. Shift 0 on 16'h7FFF gives 16'h7FFF.
- **Reset mid-frame:** assert `rst` in SEND_R. The next cycle shows all outputs at reset values with no `done` pulse. A subsequent `play` restarts at address 0.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S playback path.
//   player_state_t : playback FSM states
//   WS_LEFT/RIGHT  : word-select encoding on the controller input
//   BITS           : default sample width, shared with i2s_controller
package i2s_pkg;

  parameter int unsigned BITS = 16;

  localparam logic WS_LEFT  = 1'b1;
  localparam logic WS_RIGHT = 1'b0;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWaitRom,
    StSendL,
    StSendR,
    StDone
  } player_state_t;

endpackage

// File: rtl/i2s_sample_player_if.sv
// Ready/valid sample stream into the I2S controller.
//   o_data  : sample word
//   o_ws    : channel tag, 1 = left, 0 = right
//   o_valid : sample valid
//   o_ready : controller ready
// master = sample source (player), slave = I2S controller.
interface i2s_sample_player_if
  import i2s_pkg::*;
#(
  parameter int unsigned W = BITS
);
  logic [W-1:0] o_data;
  logic         o_ws;
  logic         o_valid;
  logic         o_ready;

  modport master (output o_data, output o_ws, output o_valid, input o_ready);
  modport slave  (input o_data, input o_ws, input o_valid, output o_ready);
endinterface

// File: rtl/sample_scaler.sv
// Registered sign-preserving attenuator: q <= data >>> shift on load.
//   clk, rst : clock, synchronous active-high reset (q clears to 0)
//   load     : capture enable
//   data     : W-bit two's-complement sample
//   shift    : arithmetic right shift amount 0-7
//   q        : registered scaled sample
module sample_scaler #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] data,
  input  logic [2:0]   shift,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= $signed(data) >>> shift;
    end
  end

endmodule

// File: rtl/i2s_sample_player.sv
// Streams PCM words from a synchronous block ROM into the I2S controller.
// Mono ROMs send each word as L then R; stereo ROMs are interleaved L,R.
//   clk, rst   : clock, synchronous active-high reset
//   play, stop : single-cycle start / sticky stop request
//   loop_en    : wrap to address 0 at end of memory
//   vol_shift  : attenuation shift, sampled per fetched word
//   rom_addr   : registered ROM address; rom_data: ROM read data
//   i2s        : sample stream to the controller (master side)
//   busy, done, amp_en : status; done pulses once when playback ends
module i2s_sample_player
  import i2s_pkg::*;
#(
  parameter int unsigned W        = BITS,
  parameter int unsigned L        = 50000,
  parameter int unsigned CHANNELS = 1,
  parameter int unsigned ROM_LAT  = 1,
  localparam int unsigned ADDR_W  = $clog2(L)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              play,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [2:0]        vol_shift,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [W-1:0]      rom_data,
  i2s_sample_player_if.master i2s,
  output logic              busy,
  output logic              done,
  output logic              amp_en
);

  localparam bit                STEREO    = (CHANNELS == 2);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(L - 1);
  localparam logic              LAT_LAST  = 1'(ROM_LAT - 1);

  player_state_t     state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              lat_q;
  logic              stop_q;
  logic              valid_q;
  logic              ws_q;
  logic              busy_q;
  logic              done_q;
  logic              load;
  logic              odd_word;
  logic              stop_now;

  assign load     = (state_q == StWaitRom) && (lat_q == LAT_LAST);
  // In stereo the address parity selects the channel of the fetched word.
  assign odd_word = STEREO && addr_q[0];
  // A stop arriving on the final handshake cycle still ends this frame.
  assign stop_now = stop_q || stop;

  sample_scaler #(
    .W (W)
  ) u_scaler (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .data  (rom_data),
    .shift (vol_shift),
    .q     (i2s.o_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      lat_q   <= 1'b0;
      stop_q  <= 1'b0;
      valid_q <= 1'b0;
      ws_q    <= WS_LEFT;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q != StIdle && stop) stop_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (play) begin
            addr_q  <= '0;
            stop_q  <= stop;
            busy_q  <= 1'b1;
            state_q <= StFetch;
          end
        end
        StFetch: begin
          lat_q   <= 1'b0;
          state_q <= StWaitRom;
        end
        StWaitRom: begin
          if (lat_q == LAT_LAST) begin
            valid_q <= 1'b1;
            ws_q    <= odd_word ? WS_RIGHT : WS_LEFT;
            state_q <= odd_word ? StSendR : StSendL;
          end else begin
            lat_q <= lat_q + 1'b1;
          end
        end
        StSendL: begin
          if (i2s.o_ready) begin
            if (STEREO) begin
              valid_q <= 1'b0;
              addr_q  <= addr_q + 1'b1;
              state_q <= StFetch;
            end else begin
              ws_q    <= WS_RIGHT;
              state_q <= StSendR;
            end
          end
        end
        StSendR: begin
          if (i2s.o_ready) begin
            valid_q <= 1'b0;
            if (stop_now || (addr_q == LAST_ADDR && !loop_en)) begin
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              // Compare before incrementing so the address never leaves 0..L-1.
              addr_q  <= (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
              state_q <= StFetch;
            end
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rom_addr    = addr_q;
  assign i2s.o_valid = valid_q;
  assign i2s.o_ws    = ws_q;
  assign busy        = busy_q;
  assign amp_en      = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_i2s_sample_player.sv
// Bench for i2s_sample_player: a mono DUT (L=4, ROM_LAT=1) and a stereo DUT
// (L=6, ROM_LAT=2) share stimulus; sel picks which one a run targets.
// Expected output streams come from a frame-level model of the ROM contents.
module tb_i2s_sample_player;

  logic clk = 1'b0;
  logic rst, play, stop, loop_en, ready, sel;
  logic [2:0] vol_shift;

  always #5 clk = ~clk;

  logic [15:0] rom_m [4];
  logic [15:0] rom_s [6];

  logic [1:0]  m_addr;
  logic [2:0]  s_addr;
  logic [15:0] m_rom_data, s_rom_p1, s_rom_data;
  logic m_busy, m_done, m_amp, s_busy, s_done, s_amp;

  i2s_sample_player_if #(.W(16)) m_if ();
  i2s_sample_player_if #(.W(16)) s_if ();

  assign m_if.o_ready = ready;
  assign s_if.o_ready = ready;

  i2s_sample_player #(.W(16), .L(4), .CHANNELS(1), .ROM_LAT(1)) u_mono (
    .clk       (clk),
    .rst       (rst),
    .play      (play & ~sel),
    .stop      (stop),
    .loop_en   (loop_en),
    .vol_shift (vol_shift),
    .rom_addr  (m_addr),
    .rom_data  (m_rom_data),
    .i2s       (m_if),
    .busy      (m_busy),
    .done      (m_done),
    .amp_en    (m_amp)
  );

  i2s_sample_player #(.W(16), .L(6), .CHANNELS(2), .ROM_LAT(2)) u_stereo (
    .clk       (clk),
    .rst       (rst),
    .play      (play & sel),
    .stop      (stop),
    .loop_en   (loop_en),
    .vol_shift (vol_shift),
    .rom_addr  (s_addr),
    .rom_data  (s_rom_data),
    .i2s       (s_if),
    .busy      (s_busy),
    .done      (s_done),
    .amp_en    (s_amp)
  );

  // Synchronous ROM models with latency 1 and 2.
  always @(posedge clk) begin
    m_rom_data <= rom_m[m_addr];
    s_rom_p1   <= (s_addr < 3'd6) ? rom_s[s_addr] : 16'hDEAD;
    s_rom_data <= s_rom_p1;
  end

  logic cur_valid, cur_ws, cur_busy, cur_done, cur_amp;
  logic [15:0] cur_data;
  logic [2:0]  cur_addr;
  assign cur_valid = sel ? s_if.o_valid : m_if.o_valid;
  assign cur_ws    = sel ? s_if.o_ws    : m_if.o_ws;
  assign cur_data  = sel ? s_if.o_data  : m_if.o_data;
  assign cur_busy  = sel ? s_busy       : m_busy;
  assign cur_done  = sel ? s_done       : m_done;
  assign cur_amp   = sel ? s_amp        : m_amp;
  assign cur_addr  = sel ? s_addr       : {1'b0, m_addr};

  int n_checks = 0;
  int n_pass   = 0;
  logic [16:0] obs_q [$];
  logic [16:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Attenuation as floor division by 2^sh of the signed word.
  function automatic logic [15:0] scale(input logic [15:0] w, input int sh);
    int v, d, r;
    v = (w >= 16'h8000) ? int'(w) - 65536 : int'(w);
    d = 1 << sh;
    r = (v >= 0) ? v / d : -((-v + d - 1) / d);
    return 16'(r);
  endfunction

  // Expected {ws,data} stream for nframes frames starting at address 0.
  task automatic build_expected(input bit st, input int nframes, input int vol);
    int a;
    exp_q.delete();
    for (int f = 0; f < nframes; f++) begin
      if (st) begin
        a = (2 * f) % 6;
        exp_q.push_back({1'b1, scale(rom_s[a], vol)});
        exp_q.push_back({1'b0, scale(rom_s[a + 1], vol)});
      end else begin
        a = f % 4;
        exp_q.push_back({1'b1, scale(rom_m[a], vol)});
        exp_q.push_back({1'b0, scale(rom_m[a], vol)});
      end
    end
  endtask

  // stop_at: 0 = no stop, -1 = stop with play, k>0 = stop during L of frame k.
  task automatic run(input bit st, input int stop_at, input bit lp, input int vol,
                     input int ready_pct, input bit hold5);
    int fpp, nframes, hs, last_hs, first_v, hold_left;
    bit fin, held, prev_stall, stopped;
    logic [16:0] prev;
    fpp = st ? 3 : 4;
    if (stop_at < 0) nframes = 1;
    else if (stop_at == 0) nframes = fpp;
    else if (lp) nframes = stop_at;
    else nframes = (stop_at < fpp) ? stop_at : fpp;
    build_expected(st, nframes, vol);
    obs_q.delete();
    sel = st; loop_en = lp; vol_shift = 3'(vol);
    hs = 0; last_hs = -10; first_v = -1; hold_left = 0;
    fin = 0; held = 0; prev_stall = 0; stopped = 0; prev = '0;
    play = 1'b1; stop = (stop_at < 0);
    step();
    play = 1'b0; stop = 1'b0;
    check("busy_start", cur_busy, 1);
    check("amp_start", cur_amp, 1);
    for (int cyc = 1; cyc < 2000 && !fin; cyc++) begin
      stop = 1'b0;
      check("addr_range", (cur_addr <= (st ? 3'd5 : 3'd3)), 1);
      if (cur_done) begin
        check("done_lat", cyc, last_hs + 1);
        check("busy_in_done", cur_busy, 1);
        play = 1'b0; ready = 1'b0;
        step();
        check("busy_after", cur_busy, 0);
        check("amp_after", cur_amp, 0);
        check("done_pulse", cur_done, 0);
        fin = 1;
      end else begin
        if (prev_stall) begin
          check("hold_valid", cur_valid, 1);
          check("hold_data", {cur_ws, cur_data}, prev);
        end
        if (cur_valid && first_v < 0) first_v = cyc;
        if (hold_left > 0) begin
          ready = 1'b0;
          hold_left--;
        end else if (hold5 && !held && cur_valid && cur_ws && hs == 2) begin
          ready = 1'b0;
          hold_left = 4;
          held = 1;
        end else begin
          ready = ($urandom_range(99) < ready_pct);
        end
        if (stop_at > 0 && !stopped && cur_valid && cur_ws && hs == 2 * (stop_at - 1)) begin
          stop = 1'b1;
          stopped = 1;
        end
        play = cur_busy && ($urandom_range(15) == 0);
        if (cur_valid && ready) begin
          obs_q.push_back({cur_ws, cur_data});
          hs++;
          last_hs = cyc;
        end
        prev_stall = cur_valid && !ready;
        prev = {cur_ws, cur_data};
        step();
      end
    end
    play = 1'b0; stop = 1'b0;
    if (!fin) check("timeout", 0, 1);
    check("latency", first_v, st ? 4 : 3);
    check("count", obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      check($sformatf("seq%0d", i), obs_q[i], exp_q[i]);
  endtask

  initial begin
    bit seen;
    int st_r, lp_r, stop_r;
    rst = 1'b1; play = 1'b0; stop = 1'b0; loop_en = 1'b0; ready = 1'b0; sel = 1'b0;
    vol_shift = 3'd0;
    for (int i = 0; i < 4; i++) rom_m[i] = 16'(i + 1);
    for (int i = 0; i < 6; i++) rom_s[i] = 16'hA000 + 16'(i);
    step(); step();
    check("rst_valid", m_if.o_valid, 0);
    check("rst_ws", m_if.o_ws, 1);
    check("rst_data", m_if.o_data, 0);
    check("rst_busy", m_busy, 0);
    check("rst_done", m_done, 0);
    check("rst_amp", m_amp, 0);
    check("rst_addr", m_addr, 0);
    check("rst_s_valid", s_if.o_valid, 0);
    check("rst_s_addr", s_addr, 0);
    rst = 1'b0;
    step();

    // Stop in idle is ignored.
    stop = 1'b1; step(); stop = 1'b0; step();
    check("idle_stop", m_busy, 0);

    run(0, 0, 0, 0, 100, 0);   // mono one-shot 1..4
    run(1, 0, 0, 0, 100, 0);   // stereo one-shot
    run(0, 0, 0, 0, 100, 1);   // 5-cycle backpressure in SEND_L
    run(0, 6, 1, 0, 100, 0);   // loop wrap then stop
    run(0, -1, 0, 0, 100, 0);  // play+stop together: one frame

    rom_m[0] = 16'h8000;
    run(0, -1, 0, 3, 100, 0);
    if (obs_q.size() > 0) check("vol3", obs_q[0][15:0], 16'hF000);
    run(0, -1, 0, 7, 100, 0);
    if (obs_q.size() > 0) check("vol7", obs_q[0][15:0], 16'hFF00);
    rom_m[0] = 16'h7FFF;
    run(0, -1, 0, 0, 100, 0);
    if (obs_q.size() > 0) check("vol0", obs_q[0][15:0], 16'h7FFF);

    // Reset while SEND_R is pending.
    sel = 1'b0; loop_en = 1'b0; vol_shift = 3'd0; ready = 1'b1;
    play = 1'b1; step(); play = 1'b0;
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (m_if.o_valid && !m_if.o_ws) begin
        seen = 1;
        ready = 1'b0;
        rst = 1'b1;
      end else begin
        step();
      end
    end
    check("midrst_seen", seen, 1);
    step();
    check("midrst_valid", m_if.o_valid, 0);
    check("midrst_ws", m_if.o_ws, 1);
    check("midrst_data", m_if.o_data, 0);
    check("midrst_busy", m_busy, 0);
    check("midrst_done", m_done, 0);
    check("midrst_amp", m_amp, 0);
    check("midrst_addr", m_addr, 0);
    rst = 1'b0;
    step();
    check("midrst_nodone", m_done, 0);
    run(0, 0, 0, 0, 100, 0);

    // Randomized runs.
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < 4; i++) rom_m[i] = 16'($urandom);
      for (int i = 0; i < 6; i++) rom_s[i] = 16'($urandom);
      st_r = $urandom_range(1);
      lp_r = $urandom_range(1);
      stop_r = lp_r ? $urandom_range(8, 1) : $urandom_range(5) - 1;
      run(st_r[0], stop_r, lp_r[0], $urandom_range(7), $urandom_range(100, 30), 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
